result_monitor: RTL and testbench
=================================

Name: result_monitor

Overview:
- Synthesizable end-of-test monitor directly downstream of the pipelined MIPS core; consumes the core's 32-bit result bus.
- Replaces free-running cycle-count termination with a decided verdict: PASS when result settles on a known value, FAIL on timeout.
- Reports cycle count, result-change count, last result and an optional MISR signature, for use by benches and by an FPGA status LED/UART.

Parameters:
- WIDTH, 32, result bus width
- CNT_W, 8, width of cycle counter
- TIMEOUT, 33, RUN cycles before FAIL; must be < 2^CNT_W
- PASS_VALUE, 32'h0000_0007, result value that signals test success
- STABLE, 4, consecutive RUN samples at PASS_VALUE required for PASS; 1..15

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- result  in  WIDTH  core result bus, sampled every clk
- done  out  1  verdict reached (PASS or FAIL)
- pass  out  1  PASS verdict
- fail  out  1  FAIL verdict
- cycles  out  CNT_W  number of RUN samples taken
- changes  out  8  number of result value changes seen in RUN, saturating at 255
- last_result  out  WIDTH  most recent result value that differed from its predecessor
- signature  out  32  MISR of result stream (see Optional Feature)

Behaviour:
- Reset (reset==0, async): state=IDLE; done/pass/fail=0; cycles=0; changes=0; last_result=0; prev=0; match_cnt=0; signature=32'h0000_0001. All outputs registered.
- States: IDLE -> RUN -> {PASS, FAIL}; PASS and FAIL are terminal until reset.
- IDLE: exactly one edge after reset release; prev<=result, last_result<=result; -> RUN. No count, no match check.
- RUN, every edge:
  - cycles<=cycles+1.
  - If result!=prev: changes<=changes+1 (saturate 255), prev<=result, last_result<=result.
  - match_nxt = (result==PASS_VALUE) ? match_cnt+1 : 0; match_cnt<=match_nxt.
  - If match_nxt==STABLE: -> PASS; pass=1, done=1 on same edge.
  - Else if cycles+1==TIMEOUT: -> FAIL; fail=1, done=1 on same edge.
  - PASS has priority over FAIL when both conditions occur on the same edge.
- PASS/FAIL: all counters, last_result, signature frozen; result ignored; pass/fail/done held.
- pass and fail never both 1; done == pass|fail at all times.
- Reset asserted mid-RUN or in a terminal state: immediate return to reset values; IDLE re-entered on first edge after release.
- A match started in IDLE does not count; PASS needs STABLE samples taken in RUN.

Optional Feature:
- Macro RESULT_MISR_EN.
- Defined: in RUN, each edge: fb = sig[31]^sig[21]^sig[1]^sig[0]; sig <= {sig[30:0], fb} ^ result[31:0] (result zero-extended or truncated to 32). No update in IDLE/PASS/FAIL. Reset seed 32'h0000_0001.
- Not defined: no MISR logic; signature tied to 32'h0000_0000.

Test Plan:
- result=7 constant from reset release -> pass=1, done=1 on 5th edge after release (IDLE+4 RUN); cycles=4, changes=0, last_result=7.
- result=3 constant -> fail=1 on 34th edge after release; cycles=33, changes=0, pass=0; outputs frozen 10 further cycles.
- RUN samples 7,7,7,3,7,7,7,7 -> no pass at sample 3 (interrupted); pass at 8th RUN sample; cycles=8, changes=2, last_result=7.
- result=3 for RUN samples 1..29, 7 from sample 30 -> match reaches 4 at sample 33 (timeout edge) -> pass=1, fail=0, cycles=33.
- reset pulsed low mid-RUN at cycles=10, between edges -> outputs zero immediately; after release, pass with result=7 gives cycles=4 again.
- RESULT_MISR_EN, result=0 for 3 RUN samples then 7 held -> signature 0x3, 0x6, 0xD after samples 1..3; frozen after pass.

Source files
------------

// File: rtl/result_monitor.sv
// -----------------------------------------------------------------------------
// result_monitor
//   End-of-test monitor placed directly after the pipelined MIPS core. It
//   watches the core's result bus and reaches a verdict: PASS once the result
//   has sat at PASS_VALUE for STABLE consecutive RUN samples, FAIL when TIMEOUT
//   RUN samples have gone by without that. When the verdict is reached, every
//   counter and the signature stop changing until reset.
//
//   Optional feature macro: RESULT_MISR_EN
//     defined   - 32-bit MISR compacts the result stream during RUN
//     undefined - no MISR logic; signature is tied to zero
//
// Ports
//   clk         in   1      system clock, all state on the rising edge
//   reset       in   1      asynchronous active-low reset
//   result      in   WIDTH  core result bus, sampled every clock
//   done        out  1      verdict reached (pass | fail)
//   pass        out  1      PASS verdict
//   fail        out  1      FAIL verdict
//   cycles      out  CNT_W  number of RUN samples taken
//   changes     out  8      result changes seen in RUN, saturating at 255
//   last_result out  WIDTH  most recent result value that differed from the last
//   signature   out  32     MISR signature of the result stream
// -----------------------------------------------------------------------------
module result_monitor #(
  parameter int unsigned            WIDTH      = 32,
  parameter int unsigned            CNT_W      = 8,
  parameter int unsigned            TIMEOUT    = 33,
  parameter logic [WIDTH-1:0]       PASS_VALUE = WIDTH'(32'h0000_0007),
  parameter int unsigned            STABLE     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] result,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] cycles,
  output logic [7:0]       changes,
  output logic [WIDTH-1:0] last_result,
  output logic [31:0]      signature
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       STABLE_C  = 4'(STABLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [7:0]         changes_q, changes_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [3:0]         match_q, match_d;
  logic [3:0]         match_nxt_s;

`ifdef RESULT_MISR_EN
  logic [31:0]        sig_q, sig_d;
  logic [31:0]        res32_s;

  // One MISR step: taps 31,21,1,0 feed the shifted-in bit, then fold in data.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] data);
    logic fb;
    fb = sig[31] ^ sig[21] ^ sig[1] ^ sig[0];
    return {sig[30:0], fb} ^ data;
  endfunction

  // Result zero-extended or truncated to the 32-bit MISR width.
  always_comb begin
    res32_s = 32'(result);
  end
`endif

  // Match counter candidate: only consecutive samples at PASS_VALUE count.
  always_comb begin
    if (result == PASS_VALUE) begin
      match_nxt_s = match_q + 4'd1;
    end else begin
      match_nxt_s = 4'd0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; PASS is tested before the timeout so it wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (match_nxt_s == STABLE_C) begin
          state_d = S_PASS;
        end else if (cycles_q + CNT_W'(1) == TIMEOUT_C) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PASS:  state_d = S_PASS;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end

  // Verdict outputs decoded from the next state so they rise on the deciding edge.
  always_comb begin
    pass_d = (state_d == S_PASS);
    fail_d = (state_d == S_FAIL);
    done_d = pass_d | fail_d;
  end

  // Datapath next-state: counters and captured values move only in IDLE/RUN.
  always_comb begin
    cycles_d  = cycles_q;
    changes_d = changes_q;
    last_d    = last_q;
    prev_d    = prev_q;
    match_d   = match_q;
`ifdef RESULT_MISR_EN
    sig_d     = sig_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Prime the change detector; nothing is counted on this edge.
        prev_d = result;
        last_d = result;
      end
      S_RUN: begin
        cycles_d = cycles_q + CNT_W'(1);
        if (result != prev_q) begin
          if (changes_q != 8'hFF) begin
            changes_d = changes_q + 8'd1;
          end else begin
            changes_d = changes_q;
          end
          prev_d = result;
          last_d = result;
        end else begin
          prev_d = prev_q;
        end
        match_d = match_nxt_s;
`ifdef RESULT_MISR_EN
        sig_d = misr_step(sig_q, res32_s);
`endif
      end
      S_PASS, S_FAIL: begin
        cycles_d = cycles_q;
      end
      default: begin
        cycles_d = cycles_q;
      end
    endcase
  end

  // Datapath and verdict registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
      cycles_q  <= '0;
      changes_q <= 8'd0;
      last_q    <= '0;
      prev_q    <= '0;
      match_q   <= 4'd0;
    end else begin
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
      cycles_q  <= cycles_d;
      changes_q <= changes_d;
      last_q    <= last_d;
      prev_q    <= prev_d;
      match_q   <= match_d;
    end
  end

`ifdef RESULT_MISR_EN
  // Signature register, seeded with 1 so an all-zero stream still evolves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= 32'h0000_0001;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`else
  assign signature = 32'h0000_0000;
`endif

  assign pass        = pass_q;
  assign fail        = fail_q;
  assign done        = done_q;
  assign cycles      = cycles_q;
  assign changes     = changes_q;
  assign last_result = last_q;

endmodule

// File: tb/tb_result_monitor.sv
// Scoreboard bench for result_monitor: each case pushes its expected verdict,
// a monitor process pops and compares when done rises.
module tb_result_monitor;

`ifdef RESULT_MISR_EN
  localparam bit MISR_ON = 1'b1;
`else
  localparam bit MISR_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] result;
  logic        done, pass, fail;
  logic [7:0]  cycles;
  logic [7:0]  changes;
  logic [31:0] last_result;
  logic [31:0] signature;

  typedef struct {
    logic        p;
    logic        f;
    logic [31:0] cyc;
    logic [31:0] chg;
    logic [31:0] last;
    logic [31:0] sig;
    logic        sig_chk;
    int          edge_n;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] stim_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_cnt;
  bit          seen;

  result_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .result      (result),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .cycles      (cycles),
    .changes     (changes),
    .last_result (last_result),
    .signature   (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edges since reset release; the IDLE edge is edge 1
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop when a verdict appears.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("done_is_or", done, pass | fail);
      chk("not_both", pass & fail, 1'b0);
      if (done && !seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          chk("unexpected_verdict", done, 1'b0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("verdict_edge", edge_cnt, e.edge_n);
          chk("pass", pass, e.p);
          chk("fail", fail, e.f);
          chk("cycles", cycles, e.cyc);
          chk("changes", changes, e.chg);
          chk("last_result", last_result, e.last);
          if (e.sig_chk) chk("signature", signature, e.sig);
        end
      end else if (!done) begin
        seen = 1'b0;
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass"}, pass, 1'b0);
    chk({tag, "_fail"}, fail, 1'b0);
    chk({tag, "_cycles"}, cycles, 32'd0);
    chk({tag, "_changes"}, changes, 32'd0);
    chk({tag, "_last"}, last_result, 32'd0);
    chk({tag, "_sig"}, signature, MISR_ON ? 32'h1 : 32'h0);
  endtask

  // Reset, release with stim_q[0] at the IDLE edge, then feed RUN samples.
  task automatic run_case(input string name, input exp_t e, input bit probe);
    logic [31:0] sig_exp [3];
    int          last_i;
    bit          got;
    sig_exp[0] = 32'h3; sig_exp[1] = 32'h6; sig_exp[2] = 32'hD;
    last_i = stim_q.size() - 1;
    @(negedge clk); #2;
    reset  = 1'b0;
    result = stim_q[0];
    sb_q.push_back(e);
    @(negedge clk); #2;
    reset = 1'b1;
    got = 1'b0;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk); #2;
      if (probe && MISR_ON && j >= 2 && j <= 4)
        chk($sformatf("%s_misr_s%0d", name, j - 1), signature, sig_exp[j-2]);
      if (done) begin
        got = 1'b1;
        break;
      end
      result = stim_q[(j - 1 > last_i) ? last_i : j - 1];
    end
    if (!got) chk({name, "_timeout_no_verdict"}, done, 1'b1);
    // verdict must stay frozen while result wanders
    for (int k = 0; k < 10; k++) begin
      result = 32'hA5A5_0000 + 32'(k * 3 + 7);
      @(negedge clk); #2;
    end
    chk({name, "_frz_pass"}, pass, e.p);
    chk({name, "_frz_fail"}, fail, e.f);
    chk({name, "_frz_cycles"}, cycles, e.cyc);
    chk({name, "_frz_changes"}, changes, e.chg);
    chk({name, "_frz_last"}, last_result, e.last);
    if (e.sig_chk) chk({name, "_frz_sig"}, signature, e.sig);
  endtask

  function automatic exp_t mk(logic p, logic f, int cyc, int chg, logic [31:0] last, int edge_n);
    exp_t e;
    e.p = p; e.f = f; e.cyc = 32'(cyc); e.chg = 32'(chg); e.last = last;
    e.sig = 32'h0; e.sig_chk = !MISR_ON; e.edge_n = edge_n;
    return e;
  endfunction

  initial begin
    exp_t e;
    bit   hit;
    seen   = 1'b0;
    reset  = 1'b0;
    result = 32'h0;
    #3;
    check_reset_state("por");

    // constant 7: pass after IDLE + 4 RUN samples
    stim_q = {32'd7};
    run_case("const7", mk(1'b1, 1'b0, 4, 0, 32'd7, 5), 1'b0);

    // constant 3: timeout on 34th edge
    stim_q = {32'd3};
    run_case("const3", mk(1'b0, 1'b1, 33, 0, 32'd3, 34), 1'b0);

    // interrupted match then pass on 8th sample
    stim_q = {32'd7, 32'd7, 32'd7, 32'd3, 32'd7};
    run_case("interrupt", mk(1'b1, 1'b0, 8, 2, 32'd7, 9), 1'b0);

    // pass and timeout coincide: pass wins
    stim_q = {};
    for (int i = 0; i < 29; i++) stim_q.push_back(32'd3);
    stim_q.push_back(32'd7);
    run_case("tie", mk(1'b1, 1'b0, 33, 1, 32'd7, 34), 1'b0);

    // reset mid-RUN at cycles==10
    stim_q = {32'd3};
    @(negedge clk); #2;
    reset = 1'b0; result = 32'd3;
    @(negedge clk); #2;
    reset = 1'b1;
    hit = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk); #2;
      if (cycles == 8'd10) begin
        hit = 1'b1;
        break;
      end
    end
    chk("midrun_reached_10", hit, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    stim_q = {32'd7};
    run_case("after_rst", mk(1'b1, 1'b0, 4, 0, 32'd7, 5), 1'b0);

    // MISR stream: 0,0,0 then 7 held -> pass on sample 7
    stim_q = {32'd0, 32'd0, 32'd0, 32'd7};
    e = mk(1'b1, 1'b0, 7, 1, 32'd7, 8);
    e.sig_chk = 1'b1;
    e.sig     = MISR_ON ? 32'h0000_00F4 : 32'h0;
    run_case("misr", e, 1'b1);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
